clock_div_gen: RTL and testbench

- Synthesizable multi-channel programmable clock divider, the successor to the simulation-only clock generator.
- Derives CHANNELS divided clocks and matching single-cycle tick enables from the system clock CLK.
- Divisor values are runtime-programmable through a valid/ready load port and are applied glitch-free at period boundaries.
- Feeds the peripheral timers and slow-clock domains of the CPU.

---
 rtl/clock_div_gen.sv | 110 +++++++++++
 tb/tb_clock_div_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_div_gen.sv
// clock_div_gen: multi-channel programmable clock divider.
// Each channel divides CLK by a runtime-programmable divisor. It produces a
// flop-driven divided clock and a single-cycle tick on the last cycle of each
// period. New divisors arrive through a valid/ready port and wait in a shadow
// register. They take effect at a period boundary, so no runt pulses appear.
// Ports:
//   CLK        system clock, rising edge
//   RST_n      asynchronous active-low reset
//   EN         per-channel run enable
//   SYNC       global phase realign pulse
//   LOAD_VALID divisor load request
//   LOAD_READY load port can accept (combinational on LOAD_CH)
//   LOAD_CH    target channel of a load
//   DIV_IN     new divisor value
//   CLK_OUT    divided clock per channel
//   TICK       one-cycle pulse on the last cycle of each period
module clock_div_gen #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned DIV_WIDTH = 16,
  parameter int unsigned RESET_DIV = 2,
  localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic [CHANNELS-1:0]  EN,
  input  logic                 SYNC,
  input  logic                 LOAD_VALID,
  output logic                 LOAD_READY,
  input  logic [CH_W-1:0]      LOAD_CH,
  input  logic [DIV_WIDTH-1:0] DIV_IN,
  output logic [CHANNELS-1:0]  CLK_OUT,
  output logic [CHANNELS-1:0]  TICK
);

  // One extra bit so that (div+1)>>1 cannot overflow at the all-ones divisor.
  localparam int unsigned HW = DIV_WIDTH + 1;

  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] accept;

  // Load port decode. An out-of-range LOAD_CH matches no channel, so it is never ready.
  always_comb begin
    LOAD_READY = 1'b0;
    accept     = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (LOAD_CH == CH_W'(c)) begin
        LOAD_READY = ~pending[c];
        accept[c]  = LOAD_VALID & ~pending[c];
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] shadow_q;
    logic                 pend_q;
    logic                 clk_q;
    logic                 running;
    logic                 wrap;
    logic [HW-1:0]        half;

    assign running    = EN[g] & (div_q != '0);
    assign wrap       = (cnt_q == div_q - DIV_WIDTH'(1));
    assign half       = (HW'(div_q) + HW'(1)) >> 1;
    assign TICK[g]    = running & wrap;
    assign pending[g] = pend_q;
    assign CLK_OUT[g] = clk_q;

    // Counter, active divisor, shadow divisor and clock flop for one channel.
    always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
        cnt_q    <= '0;
        div_q    <= DIV_WIDTH'(RESET_DIV);
        shadow_q <= '0;
        pend_q   <= 1'b0;
        clk_q    <= 1'b0;
      end else begin
        if (!running || SYNC) begin
          // A stopped or realigned channel restarts its phase and picks up any pending divisor.
          // The clock flop goes high only on the SYNC path, because a stopped channel holds its clock low.
          cnt_q <= '0;
          clk_q <= running;
          if (pend_q) begin
            div_q  <= shadow_q;
            pend_q <= 1'b0;
          end
        end else begin
          // High for the first ceil(div/2) counts. The flop adds one cycle of lag.
          clk_q <= (HW'(cnt_q) < half);
          if (wrap) begin
            cnt_q <= '0;
            if (pend_q) begin
              div_q  <= shadow_q;
              pend_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + DIV_WIDTH'(1);
          end
        end
        // A load is only accepted while nothing is pending, so it never coincides with an apply.
        if (accept[g]) begin
          shadow_q <= DIV_IN;
          pend_q   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_div_gen.sv
// Testbench for clock_div_gen. It checks the divider against an arithmetic
// period model on every cycle. Directed scenarios pin the model with
// hand-computed values, and a randomized phase follows them.
module tb_clock_div_gen;

  localparam int CH = 5;
  localparam int DW = 4;
  localparam int RD = 2;
  localparam int CW = 3;

  logic          CLK = 1'b0;
  logic          RST_n;
  logic [CH-1:0] EN;
  logic          SYNC;
  logic          LOAD_VALID;
  logic          LOAD_READY;
  logic [CW-1:0] LOAD_CH;
  logic [DW-1:0] DIV_IN;
  logic [CH-1:0] CLK_OUT;
  logic [CH-1:0] TICK;

  int errors = 0;
  int checks = 0;
  bit cmp_on = 1'b0;

  clock_div_gen #(.CHANNELS(CH), .DIV_WIDTH(DW), .RESET_DIV(RD)) dut (
    .CLK(CLK), .RST_n(RST_n), .EN(EN), .SYNC(SYNC),
    .LOAD_VALID(LOAD_VALID), .LOAD_READY(LOAD_READY), .LOAD_CH(LOAD_CH),
    .DIV_IN(DIV_IN), .CLK_OUT(CLK_OUT), .TICK(TICK)
  );

  always #5 CLK = ~CLK;

  function void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model. Each channel tracks its position inside the current period.
  int m_pos [CH];
  int m_div [CH];
  int m_sh  [CH];
  bit m_pend[CH];
  bit m_co  [CH];

  always @(posedge CLK or negedge RST_n) begin : model
    int acc;
    int lc;
    if (!RST_n) begin
      for (int c = 0; c < CH; c++) begin
        m_pos[c] = 0; m_div[c] = RD; m_sh[c] = 0; m_pend[c] = 0; m_co[c] = 0;
      end
    end else begin
      acc = -1;
      lc  = int'(LOAD_CH);
      if (LOAD_VALID && lc < CH) begin
        if (!m_pend[lc]) acc = lc;
      end
      for (int c = 0; c < CH; c++) begin
        if (!EN[c] || m_div[c] == 0 || SYNC) begin
          m_co[c]  = (EN[c] && m_div[c] != 0);
          m_pos[c] = 0;
          if (m_pend[c]) begin m_div[c] = m_sh[c]; m_pend[c] = 0; end
        end else begin
          m_co[c] = (m_pos[c] < (m_div[c] + 1) / 2);
          if (m_pos[c] == m_div[c] - 1) begin
            m_pos[c] = 0;
            if (m_pend[c]) begin m_div[c] = m_sh[c]; m_pend[c] = 0; end
          end else begin
            m_pos[c] = m_pos[c] + 1;
          end
        end
      end
      if (acc >= 0) begin
        m_sh[acc]   = int'(DIV_IN);
        m_pend[acc] = 1;
      end
    end
  end

  function bit exp_tick(input int c);
    return EN[c] && m_div[c] != 0 && m_pos[c] == m_div[c] - 1;
  endfunction

  function bit exp_ready();
    int lc;
    lc = int'(LOAD_CH);
    if (lc >= CH) return 1'b0;
    return !m_pend[lc];
  endfunction

  // Compare process: runs mid-low-phase, after inputs driven at the falling edge have settled.
  always @(negedge CLK) begin
    #2;
    if (cmp_on) begin
      for (int c = 0; c < CH; c++) begin
        chk($sformatf("model_clk_out[%0d]", c), 32'(CLK_OUT[c]), 32'(m_co[c]));
        chk($sformatf("model_tick[%0d]", c), 32'(TICK[c]), 32'(exp_tick(c)));
      end
      chk("model_ready", 32'(LOAD_READY), 32'(exp_ready()));
    end
  end

  task automatic count_win(input int n, input int c, output int hi, output int tk);
    hi = 0; tk = 0;
    repeat (n) begin
      @(posedge CLK); #3;
      hi += int'(CLK_OUT[c]);
      tk += int'(TICK[c]);
    end
  endtask

  task automatic wait_phase(input int c, input int ph);
    bit hit = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge CLK);
      if (m_pos[c] == ph) hit = 1'b1;
    end
    chk("wait_phase_reached", 32'(hit), 32'd1);
  endtask

  task automatic load(input int ch, input int d);
    @(negedge CLK);
    LOAD_VALID = 1'b1; LOAD_CH = CW'(ch); DIV_IN = DW'(d);
    @(negedge CLK);
    LOAD_VALID = 1'b0;
  endtask

  initial begin
    int hi, tk;
    RST_n = 1'b1; EN = '0; SYNC = 1'b0; LOAD_VALID = 1'b0; LOAD_CH = '0; DIV_IN = '0;
    #1 RST_n = 1'b0;
    #11;
    chk("reset_clk_out", 32'(CLK_OUT), 32'd0);
    chk("reset_tick", 32'(TICK), 32'd0);
    chk("reset_ready", 32'(LOAD_READY), 32'd1);

    // Channel 0 at the reset divisor of 2.
    @(negedge CLK);
    RST_n = 1'b1; EN = 5'b00001; cmp_on = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #3;
      chk("t1_clk_out0", 32'(CLK_OUT[0]), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("t1_tick0", 32'(TICK[0]), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("t1_idle_channels", 32'(CLK_OUT[4:1] | TICK[4:1]), 32'd0);
    end

    // Channel 1 gets divisor 5. Ready stays low until the old period wraps.
    @(negedge CLK);
    EN[1] = 1'b1; LOAD_VALID = 1'b1; LOAD_CH = 3'd1; DIV_IN = 4'd5;
    @(negedge CLK);
    LOAD_VALID = 1'b0; #1;
    chk("t2_ready_while_pending", 32'(LOAD_READY), 32'd0);
    repeat (8) @(negedge CLK);
    count_win(10, 1, hi, tk);
    chk("t2_high_cycles", 32'(hi), 32'd6);
    chk("t2_ticks", 32'(tk), 32'd2);

    // Channel 0 runs at divisor 4. At position 1 it is loaded with 6, and a second load is refused.
    load(0, 4);
    repeat (4) @(negedge CLK);
    wait_phase(0, 1);
    LOAD_VALID = 1'b1; LOAD_CH = 3'd0; DIV_IN = 4'd6;
    @(negedge CLK);
    DIV_IN = 4'd9; #1;
    chk("t3_second_load_ready", 32'(LOAD_READY), 32'd0);
    @(negedge CLK);
    LOAD_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    count_win(12, 0, hi, tk);
    chk("t3_high_cycles", 32'(hi), 32'd6);
    chk("t3_ticks", 32'(tk), 32'd2);

    // Channel 2 is stopped by divisor 0, then restarted with divisor 3.
    @(negedge CLK);
    EN[2] = 1'b1;
    load(2, 0);
    repeat (4) @(negedge CLK);
    count_win(3, 2, hi, tk);
    chk("t4_stopped_high", 32'(hi), 32'd0);
    chk("t4_stopped_ticks", 32'(tk), 32'd0);
    @(negedge CLK);
    LOAD_VALID = 1'b1; LOAD_CH = 3'd2; DIV_IN = 4'd3; #1;
    chk("t4_ready_when_stopped", 32'(LOAD_READY), 32'd1);
    @(negedge CLK);
    LOAD_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    count_win(6, 2, hi, tk);
    chk("t4_high_cycles", 32'(hi), 32'd4);
    chk("t4_ticks", 32'(tk), 32'd2);

    // Channel 0 gets divisor 3 and channel 1 gets divisor 4. After SYNC their ticks coincide every 12 cycles.
    load(0, 3);
    load(1, 4);
    repeat (13) @(negedge CLK);
    SYNC = 1'b1;
    @(negedge CLK);
    SYNC = 1'b0;
    hi = 0;
    repeat (24) begin
      @(posedge CLK); #3;
      hi += int'(TICK[0] & TICK[1]);
    end
    chk("t5_coincident_ticks", 32'(hi), 32'd2);
    @(negedge CLK);
    LOAD_VALID = 1'b1; LOAD_CH = 3'd5; DIV_IN = 4'd1; #1;
    chk("t5_out_of_range_ready", 32'(LOAD_READY), 32'd0);
    repeat (4) @(negedge CLK);
    LOAD_CH = 3'd7; #1;
    chk("t5_out_of_range_ready7", 32'(LOAD_READY), 32'd0);
    LOAD_VALID = 1'b0;

    // Reset arrives between edges while a load to channel 1 is pending.
    wait_phase(1, 0);
    LOAD_VALID = 1'b1; LOAD_CH = 3'd1; DIV_IN = 4'd7;
    @(posedge CLK); #2;
    RST_n = 1'b0; #1;
    chk("t6_clk_out_async", 32'(CLK_OUT), 32'd0);
    chk("t6_tick_async", 32'(TICK), 32'd0);
    chk("t6_ready_in_reset", 32'(LOAD_READY), 32'd1);
    LOAD_VALID = 1'b0;
    @(negedge CLK);
    RST_n = 1'b1; #1;
    chk("t6_ready_after_release", 32'(LOAD_READY), 32'd1);
    count_win(8, 1, hi, tk);
    chk("t6_high_cycles", 32'(hi), 32'd4);
    chk("t6_ticks", 32'(tk), 32'd4);

    // Randomized traffic on all inputs, with occasional reset between edges.
    for (int n = 0; n < 2500; n++) begin
      @(negedge CLK);
      if ($urandom_range(0, 15) == 0) EN[$urandom_range(0, CH - 1)] ^= 1'b1;
      SYNC       = ($urandom_range(0, 24) == 0);
      LOAD_VALID = ($urandom_range(0, 3) == 0);
      LOAD_CH    = CW'($urandom_range(0, 7));
      DIV_IN     = ($urandom_range(0, 7) == 0) ? DW'(15) : DW'($urandom_range(0, 8));
      if ($urandom_range(0, 399) == 0) begin
        #3 RST_n = 1'b0;
        #1 RST_n = 1'b1;
      end
    end

    @(negedge CLK);
    cmp_on = 1'b0;
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
